quant_tile_drain: RTL and testbench
===================================

// Module: quant_tile_drain
// PURPOSE
//  Downstream consumer of the integrated systolic/accumulate/requant stage. Captures each
//  ARRAY_SIZE x ARRAY_SIZE tile of signed int8 requantized results on the tile-valid pulse.
//  Holds tiles in a ping-pong buffer (2 tiles) and drains them row by row as a valid/ready stream
//  toward the writeback/DMA path. Decouples the fixed-latency compute pipe from a back-pressured sink.
// PARAMETERS
//  ARRAY_SIZE  4  tile edge; rows per tile and elements per output beat
//  DATA_WIDTH  8  signed element width
//  CNT_WIDTH   8  width of saturating drop counter
// PORTS
//  clk          in   1                        single clock, rising edge
//  reset_n      in   1                        asynchronous, active-low reset
//  tile_in      in   [AS][AS]x DATA_WIDTH     signed tile, tile_in[row][col]
//  tile_valid   in   1                        1-cycle pulse: tile_in is valid this cycle
//  tile_ready   out  1                        a capture this cycle would be accepted (see below)
//  flush        in   1                        sync: discard all buffered tiles
//  clear_ovf    in   1                        sync: clear overrun and drop_count
//  out_data     out  AS*DATA_WIDTH            one row; col j at [j*DATA_WIDTH +: DATA_WIDTH]
//  out_row      out  $clog2(AS)               row index of current beat
//  out_last     out  1                        current beat is final row of the tile
//  out_valid    out  1                        beat available
//  out_ready    in   1                        sink accepts beat
//  overrun      out  1                        sticky: a tile was dropped
//  drop_count   out  CNT_WIDTH                tiles dropped, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset_n=0, async): full[1:0]=0, wr_sel=0, rd_sel=0, row_cnt=0, overrun=0,
//    drop_count=0; so out_valid=0, out_last=0, out_row=0, tile_ready=1. Buffer contents: don't-care.
//  - Storage: buf[2][AS][AS]; per-buffer full flag; 1-bit wr_sel and rd_sel pointers.
//  - Release: fires when out_valid & out_ready & row_cnt==AS-1.
//    It clears full[rd_sel], toggles rd_sel and sets row_cnt=0.
//  - Beat accept without release: out_valid & out_ready & row_cnt<AS-1 -> row_cnt+1.
//  - tile_ready = !full[wr_sel] | (release & wr_sel==rd_sel). This is combinational.
//  - Capture: tile_valid & tile_ready -> buf[wr_sel]<=tile_in, full[wr_sel]<=1, wr_sel toggles.
//    If release and capture hit the same buffer in one cycle, that buffer ends full (new tile).
//  - Drop: tile_valid & !tile_ready -> tile discarded, buffers untouched, overrun<=1,
//    drop_count+1 saturating.
//  - Output: out_valid = full[rd_sel]. out_data = buf[rd_sel][row_cnt], out_row = row_cnt,
//    out_last = (row_cnt==AS-1). These are combinational from registered state.
//  - Latency: tile captured at edge N -> out_valid=1 in cycle N+1 if the buffer was empty.
//    Min drain is AS cycles/tile with out_ready held high.
//  - Stability: while out_valid & !out_ready, out_data, out_row and out_last hold constant.
//  - Order: tiles leave in capture order; rows in order 0..AS-1 within a tile.
//  - flush: full=0, wr_sel=rd_sel=0, row_cnt=0 next edge.
//    A tile_valid in the same cycle is ignored (not captured, not counted as drop).
//    overrun and drop_count are unaffected.
//  - clear_ovf: overrun=0, drop_count=0.
//    A drop in the same cycle wins: overrun=1, drop_count=1.
//  - Element bits pass through unmodified (no sign handling or saturation here).
// TESTING
//  1 tile[r][c]=r*4+c, out_ready=1 -> 4 beats next cycle.
//    row0 out_data=32'h03020100, row3=32'h0F0E0D0C with out_last=1; out_valid=0 after.
//  2 Single tile, out_ready toggled 1,0,0,1,... -> each row emitted once.
//    out_data/out_row stable while stalled; 4 handshakes total.
//  3 out_ready=0, three tile_valid pulses (A,B,C) -> A,B held, tile_ready=0 after B.
//    C dropped: overrun=1, drop_count=1; then ready=1 drains A then B only.
//  4 Both full, pulse tile_valid in the same cycle as A's final-row handshake.
//    -> tile captured into A's slot, no drop; stream order B then new tile.
//  5 Drops with drop_count=8'hFF -> stays 8'hFF. clear_ovf -> 0.
//    clear_ovf concurrent with a drop -> drop_count=1.
//  6 reset_n pulsed low mid-tile (row_cnt=2) asynchronously -> out_valid=0 immediately.
//    All counters 0 and tile_ready=1; next tile drains from row 0.
//    Also: tile of all -128 -> out_data=32'h80808080.

Source files
------------

// File: rtl/quant_tile_drain.sv
// Ping-pong tile buffer between the requant stage and the writeback stream.
// Whole tiles are captured in one cycle and drained one row per accepted beat.
module quant_tile_drain #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0]  tile_in,
    input  logic                                                   tile_valid,
    output logic                                                   tile_ready,
    input  logic                                                   flush,
    input  logic                                                   clear_ovf,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]                       out_data,
    output logic [((ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1)-1:0] out_row,
    output logic                                                   out_last,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic                                                   overrun,
    output logic [CNT_WIDTH-1:0]                                   drop_count
);

    localparam int RW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_SIZE - 1);

    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] tile_buf [2];
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          wr_sel;
    logic          rd_sel;
    logic [RW-1:0] row_cnt;

    logic beat_fire;
    logic release_tile;
    logic capture;
    logic drop;

    assign out_valid    = full[rd_sel];
    assign out_row      = row_cnt;
    assign out_last     = (row_cnt == LAST_ROW);
    assign beat_fire    = out_valid & out_ready;
    assign release_tile = beat_fire & out_last;
    // With both buffers full wr_sel equals rd_sel, so a release frees the write slot.
    assign tile_ready   = !full[wr_sel] | (release_tile & (wr_sel == rd_sel));
    assign capture      = tile_valid & tile_ready & !flush;
    assign drop         = tile_valid & !tile_ready & !flush;

    always_comb begin
        out_data = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            out_data[j*DATA_WIDTH +: DATA_WIDTH] = tile_buf[rd_sel][row_cnt][j];
        end
    end

    // Capture is applied after release so a same-slot hit leaves the new tile full.
    always_comb begin
        full_next = full;
        if (release_tile) full_next[rd_sel] = 1'b0;
        if (capture)      full_next[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (capture) tile_buf[wr_sel] <= tile_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            row_cnt <= '0;
        end else if (flush) begin
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            row_cnt <= '0;
        end else begin
            full <= full_next;
            if (capture)      wr_sel <= ~wr_sel;
            if (release_tile) rd_sel <= ~rd_sel;
            if (beat_fire)    row_cnt <= out_last ? '0 : row_cnt + 1'b1;
        end
    end

    // A drop in the same cycle as clear_ovf restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun    <= 1'b1;
            if (clear_ovf)       drop_count <= CNT_WIDTH'(1);
            else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
        end else if (clear_ovf) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_quant_tile_drain.sv
// Randomized and directed bench for quant_tile_drain against a queue-of-tiles reference model.
module tb_quant_tile_drain;

    typedef logic [3:0][3:0][7:0] tile_t;

    logic        clk = 1'b0;
    logic        reset_n;
    tile_t       tile_in;
    logic        tile_valid;
    logic        tile_ready;
    logic        flush;
    logic        clear_ovf;
    logic [31:0] out_data;
    logic [1:0]  out_row;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic [7:0]  drop_count;

    quant_tile_drain #(.ARRAY_SIZE(4), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .flush      (flush),
        .clear_ovf  (clear_ovf),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tiles waiting in capture order, current row of the head tile.
    tile_t mq[$];
    int    m_row = 0;
    bit    m_ovf = 0;
    int    m_cnt = 0;
    int    handshakes = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic tile_t randTile();
        tile_t t;
        for (int r = 0; r < 4; r++) t[r] = $urandom;
        return t;
    endfunction

    task automatic modelReset();
        mq.delete();
        m_row = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle and advances the model.
    task automatic applyStimulus(input bit tv, input tile_t t, input bit ordy, input bit fl, input bit clr);
        bit          exp_valid;
        bit          exp_ready;
        bit          rel;
        logic [31:0] exp_data;
        tile_in    = t;
        tile_valid = tv;
        out_ready  = ordy;
        flush      = fl;
        clear_ovf  = clr;
        @(negedge clk);
        exp_valid = (mq.size() > 0);
        rel       = exp_valid && ordy && (m_row == 3);
        exp_ready = (mq.size() < 2) || rel;
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        checkOutput("tile_ready", {31'b0, tile_ready}, {31'b0, exp_ready});
        checkOutput("overrun", {31'b0, overrun}, {31'b0, m_ovf});
        checkOutput("drop_count", {24'b0, drop_count}, m_cnt);
        if (exp_valid) begin
            for (int j = 0; j < 4; j++) exp_data[j*8 +: 8] = mq[0][m_row][j];
            checkOutput("out_data", out_data, exp_data);
            checkOutput("out_row", {30'b0, out_row}, m_row);
            checkOutput("out_last", {31'b0, out_last}, {31'b0, (m_row == 3)});
        end
        if (fl) begin
            mq.delete();
            m_row = 0;
        end else begin
            if (exp_valid && ordy) begin
                handshakes++;
                if (m_row == 3) begin
                    void'(mq.pop_front());
                    m_row = 0;
                end else begin
                    m_row++;
                end
            end
            if (tv && exp_ready) mq.push_back(t);
        end
        if (tv && !exp_ready && !fl) begin
            m_ovf = 1;
            m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    tile_t inc_tile;
    tile_t neg_tile;
    tile_t zero_tile;
    int    ready_pat [9] = '{1, 0, 0, 1, 0, 1, 0, 0, 1};

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                inc_tile[r][c] = 8'(r * 4 + c);
                neg_tile[r][c] = 8'h80;
            end
        zero_tile  = '0;
        reset_n    = 1'b0;
        tile_in    = '0;
        tile_valid = 1'b0;
        flush      = 1'b0;
        clear_ovf  = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_tile_ready", {31'b0, tile_ready}, 32'd1);
        checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("rst_out_row", {30'b0, out_row}, 32'd0);
        checkOutput("rst_overrun", {31'b0, overrun}, 32'd0);
        checkOutput("rst_drop_count", {24'b0, drop_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] incrementing tile, sink always ready");
        applyStimulus(1, inc_tile, 1, 0, 0);
        checkOutput("t1_row0_data", out_data, 32'h03020100);
        for (int i = 0; i < 3; i++) applyStimulus(0, zero_tile, 1, 0, 0);
        checkOutput("t1_row3_data", out_data, 32'h0F0E0D0C);
        checkOutput("t1_row3_last", {31'b0, out_last}, 32'd1);
        applyStimulus(0, zero_tile, 1, 0, 0);
        checkOutput("t1_drained", {31'b0, out_valid}, 32'd0);

        $display("[TB] single tile with stalling sink");
        applyStimulus(1, randTile(), 0, 0, 0);
        handshakes = 0;
        for (int i = 0; i < 9; i++) applyStimulus(0, zero_tile, ready_pat[i] != 0, 0, 0);
        checkOutput("t2_handshakes", handshakes, 32'd4);
        checkOutput("t2_drained", {31'b0, out_valid}, 32'd0);

        $display("[TB] overflow drops third tile");
        for (int i = 0; i < 3; i++) applyStimulus(1, randTile(), 0, 0, 0);
        checkOutput("t3_overrun", {31'b0, overrun}, 32'd1);
        checkOutput("t3_drop_count", {24'b0, drop_count}, 32'd1);
        for (int i = 0; i < 9; i++) applyStimulus(0, zero_tile, 1, 0, 0);
        checkOutput("t3_drained", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, zero_tile, 0, 0, 1);

        $display("[TB] capture on final-row release");
        applyStimulus(1, randTile(), 0, 0, 0);
        applyStimulus(1, randTile(), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, zero_tile, 1, 0, 0);
        applyStimulus(1, inc_tile, 1, 0, 0);
        checkOutput("t4_no_drop", {24'b0, drop_count}, 32'd0);
        for (int i = 0; i < 9; i++) applyStimulus(0, zero_tile, 1, 0, 0);

        $display("[TB] drop counter saturation and clear");
        applyStimulus(1, randTile(), 0, 0, 0);
        applyStimulus(1, randTile(), 0, 0, 0);
        for (int i = 0; i < 260; i++) applyStimulus(1, randTile(), 0, 0, 0);
        checkOutput("t5_saturated", {24'b0, drop_count}, 32'h0000_00FF);
        applyStimulus(0, zero_tile, 0, 0, 1);
        checkOutput("t5_cleared", {24'b0, drop_count}, 32'd0);
        applyStimulus(1, randTile(), 0, 0, 1);
        checkOutput("t5_clear_drop", {24'b0, drop_count}, 32'd1);
        applyStimulus(1, randTile(), 0, 1, 0);
        checkOutput("t5_flush_no_drop", {24'b0, drop_count}, 32'd1);

        $display("[TB] asynchronous reset mid-tile");
        applyStimulus(1, randTile(), 0, 0, 0);
        applyStimulus(0, zero_tile, 1, 0, 0);
        applyStimulus(0, zero_tile, 1, 0, 0);
        checkOutput("t6_row_before", {30'b0, out_row}, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_valid_async", {31'b0, out_valid}, 32'd0);
        checkOutput("t6_ready_async", {31'b0, tile_ready}, 32'd1);
        checkOutput("t6_row_async", {30'b0, out_row}, 32'd0);
        checkOutput("t6_cnt_async", {24'b0, drop_count}, 32'd0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, neg_tile, 0, 0, 0);
        checkOutput("t6_neg_data", out_data, 32'h80808080);
        for (int i = 0; i < 5; i++) applyStimulus(0, zero_tile, 1, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 3) == 0, randTile(), ($urandom % 4) != 0,
                          ($urandom % 97) == 0, ($urandom % 61) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
